// File: rtl/sprite_rom_loader.sv
// Writable 4x16x16 one-bit sprite store: a 32-byte valid/ready stream loads one sprite; the read port is a zero-latency mux.
// A load takes 1 start cycle + 32 transfer cycles + 1 done cycle; in_valid may stall the load indefinitely.
module sprite_rom_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] sprite_sel,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    input  logic [1:0] rd_sprite,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic       rd_pixel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  cur_sprite_q, cur_sprite_d;
    logic        wr_en;

    // One 16-bit word per (sprite, row); bit index is the column.
    logic [15:0] mem_q [64];
    logic [5:0]  wr_idx;

    assign wr_idx   = {cur_sprite_q, byte_cnt_q[4:1]};
    assign rd_pixel = mem_q[{rd_sprite, rd_row}][rd_col];

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        cur_sprite_d = cur_sprite_q;
        wr_en        = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_sprite_d = sprite_sel;
                    byte_cnt_d   = 5'd0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // Abort wins over a simultaneous transfer: nothing is written that cycle.
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    wr_en      = 1'b1;
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if (byte_cnt_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 5'd0;
            cur_sprite_q <= 2'd0;
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            cur_sprite_q <= cur_sprite_d;
            if (wr_en) begin
                if (byte_cnt_q[0]) begin
                    mem_q[wr_idx][15:8] <= in_data;
                end else begin
                    mem_q[wr_idx][7:0] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_loader.sv
// Scoreboard bench for sprite_rom_loader: stimulus queues expected done cycles and read values,
// a negedge monitor pops and compares them whenever done pulses or a read is presented.
module tb_sprite_rom_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sprite_sel = 2'd0;
    logic       abort = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, busy, done, rd_pixel;
    logic [1:0] rd_sprite = 2'd0;
    logic [3:0] rd_row = 4'd0;
    logic [3:0] rd_col = 4'd0;
    logic       rd_vld = 1'b0;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        bit exp;
        int s;
        int r;
        int c;
    } rd_t;

    int  done_q[$];
    rd_t rd_q[$];
    bit  model [4][16][16];

    logic [7:0] pat_a [32];
    logic [7:0] pat_ff [32];
    logic [7:0] pat_a5 [32];
    logic [7:0] pat_rw [32];

    sprite_rom_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sprite_sel (sprite_sel),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .rd_sprite  (rd_sprite),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_pixel   (rd_pixel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle number during the cycle following edge E is E+1.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (done_q.size() == 0) chk("unexpected done", {31'd0, done}, 32'd0);
                else chk("done cycle", edge_cnt + 1, done_q.pop_front());
            end
            if (rd_vld && rd_q.size() > 0) begin
                rd_t e;
                e = rd_q.pop_front();
                chk($sformatf("rd s%0d r%0d c%0d", e.s, e.r, e.c), {31'd0, rd_pixel}, {31'd0, e.exp});
            end
        end
    end

    task automatic rd_push(input int s, input int r, input int c, input bit exp);
        rd_t e;
        rd_sprite = s[1:0];
        rd_row    = r[3:0];
        rd_col    = c[3:0];
        e.exp = exp; e.s = s; e.r = r; e.c = c;
        rd_q.push_back(e);
        rd_vld = 1'b1;
    endtask

    task automatic rd_one(input int s, input int r, input int c, input bit exp);
        rd_push(s, r, c, exp);
        @(posedge clk); #1;
        rd_vld = 1'b0;
    endtask

    task automatic sweep();
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    rd_push(s, r, c, model[s][r][c]);
                    @(posedge clk); #1;
                end
        rd_vld = 1'b0;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    model[s][r][c] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1. toggle: in_valid alternates 1,0,1,0 starting on the start cycle.
    task automatic run_load(input logic [1:0] sel, input logic [7:0] b [32], input bit toggle,
                            input int abort_at, input int start_at, input bit rdw, input int lat);
        int idx;
        int k;
        bit xfer;
        bit pulsed;
        bit aborted;
        idx = 0; k = 1; pulsed = 1'b0; aborted = 1'b0;
        start = 1'b1; sprite_sel = sel; in_valid = toggle; in_data = b[0];
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        if (abort_at < 0) done_q.push_back(edge_cnt + lat);
        while (idx < 32 && k < 200) begin
            if (idx == abort_at) begin
                abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
                @(posedge clk); #1;
                abort = 1'b0; in_valid = 1'b0;
                chk("busy after abort", {31'd0, busy}, 32'd0);
                aborted = 1'b1;
                break;
            end
            in_valid = toggle ? (k % 2 == 0) : 1'b1;
            in_data  = b[idx];
            start    = (idx == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            sprite_sel = start ? 2'd3 : sel;
            if (rdw && idx <= 1) rd_push(0, 0, 0, idx == 1);
            else rd_vld = 1'b0;
            xfer = in_ready && in_valid;
            @(posedge clk); #1;
            start = 1'b0;
            if (xfer) begin
                for (int i = 0; i < 8; i++) model[sel][idx / 2][(idx % 2) * 8 + i] = b[idx][i];
                idx++;
            end
            k++;
        end
        in_valid = 1'b0; rd_vld = 1'b0; sprite_sel = 2'd0;
        if (!aborted) begin
            if (idx < 32) chk("load progress", idx, 32);
            for (int g = 0; g < 8 && busy; g++) begin
                @(posedge clk); #1;
            end
            chk("busy falls", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            pat_a[i]  = (i % 2 == 0) ? 8'h01 : 8'h80;
            pat_ff[i] = 8'hFF;
            pat_a5[i] = 8'hA5;
            pat_rw[i] = (i == 0) ? 8'h01 : 8'h00;
        end
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Partial load of 0xFF into sprite 0, then reset mid-cycle.
        start = 1'b1; sprite_sel = 2'd0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("busy in load", {31'd0, busy}, 32'd1);
        rd_sprite = 2'd0; rd_row = 4'd0; rd_col = 4'd0;
        @(negedge clk); #2;
        chk("pixel before reset", {31'd0, rd_pixel}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset done", {31'd0, done}, 32'd0);
        chk("mid reset pixel", {31'd0, rd_pixel}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        sweep();

        // Full load, sprite 2, continuous stream.
        run_load(2'd2, pat_a, 1'b0, -1, -1, 1'b0, 33);
        rd_one(2, 0, 0, 1'b1);
        rd_one(2, 7, 15, 1'b1);
        rd_one(2, 7, 8, 1'b0);
        rd_one(2, 15, 7, 1'b0);
        rd_one(1, 7, 0, 1'b0);
        sweep();

        // Same load under back-pressure into a cleared array.
        do_reset();
        run_load(2'd2, pat_a, 1'b1, -1, -1, 1'b0, 65);
        rd_one(2, 9, 15, 1'b1);
        rd_one(2, 9, 0, 1'b1);
        rd_one(2, 9, 1, 1'b0);
        sweep();

        // Abort after 5 bytes of 0xFF into sprite 1.
        run_load(2'd1, pat_ff, 1'b0, 5, -1, 1'b0, 0);
        rd_one(1, 1, 15, 1'b1);
        rd_one(1, 2, 7, 1'b1);
        rd_one(1, 2, 8, 1'b0);
        rd_one(1, 3, 0, 1'b0);
        sweep();

        // Start with sprite_sel=3 pulsed mid-load of sprite 0 must be ignored.
        run_load(2'd0, pat_a5, 1'b0, -1, 10, 1'b0, 33);
        rd_one(0, 0, 0, 1'b1);
        rd_one(0, 0, 1, 1'b0);
        rd_one(0, 15, 15, 1'b1);
        rd_one(3, 5, 0, 1'b0);
        sweep();

        // Read-during-write on sprite 0, row 0, col 0.
        do_reset();
        run_load(2'd0, pat_rw, 1'b0, -1, -1, 1'b1, 33);
        rd_one(0, 0, 0, 1'b1);
        rd_one(0, 0, 1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending done", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_loader.md
# sprite_rom_loader

Writable 4 × 16 × 16 one-bit sprite store that replaces the fixed `ROM/sprites16` image read by the display pixel generators. A byte stream from the game-logic side loads one full sprite at a time through a valid/ready handshake. A combinational read port addressed by sprite number, row and column serves the display side with the same addressing and zero latency as the ROM it replaces.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears the FSM, the counters and the whole sprite array.
- `start` in 1: load request; sampled only in IDLE.
- `sprite_sel` in 2: sprite to load; latched when `start` is accepted.
- `abort` in 1: cancels a load in progress.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse after the 32nd byte has been written.
- `rd_sprite` in 2: read address, sprite number.
- `rd_row` in 4: read address, row (Y).
- `rd_col` in 4: read address, column (X).
- `rd_pixel` out 1: stored bit `sprite[rd_sprite][rd_row][rd_col]`; combinational.

## Operation
- **Storage:** 1024 bits, `sprite[0..3][0..15][0..15]`, all 0 after reset.
- **FSM states:** IDLE, LOAD, DONE.
  - IDLE: `in_ready`=0, `busy`=0, `done`=0. When `start`=1, latch `sprite_sel` into `cur_sprite`, clear the 5-bit `byte_cnt`, go to LOAD.
  - LOAD: `in_ready`=1, `busy`=1. A transfer happens on any cycle with `in_valid`=1 (ready is already high).
    - A transfer writes `in_data` into row `byte_cnt[4:1]` of `cur_sprite`.
    - When `byte_cnt[0]`=0, bit i goes to column i (columns 0..7).
    - When `byte_cnt[0]`=1, bit i goes to column 8+i (columns 8..15).
    - `byte_cnt` increments on each transfer.
    - A transfer with `byte_cnt`=31 goes to DONE. `byte_cnt` wraps to 0, which is unused.
  - DONE: `in_ready`=0, `busy`=1, `done`=1 for exactly one cycle, then IDLE.
- **Stream order:** 32 bytes, row 0 first, low half of each row before high half.
- **Abort:** `abort`=1 in LOAD returns to IDLE on the next edge.
  - No write occurs in that cycle, even if `in_valid`=1.
  - Bytes already written remain; `done` is not pulsed.
  - `abort` in IDLE or DONE is ignored.
- **Start outside IDLE:** `start` in LOAD or DONE is ignored. A new load needs `start` after `busy` falls; the earliest is the cycle after DONE.
- **Read port:** `rd_pixel` is a pure combinational mux of the array, with no read/write interlock.
  - A read of a bit being written returns the old value until the write edge and the new value after it.
- **Idle bytes:** `in_data` is ignored whenever no transfer occurs.

## Timing
- **Reset values:** `in_ready`=0, `busy`=0, `done`=0, state IDLE, `byte_cnt`=0, `cur_sprite`=0. `rd_pixel` reflects the cleared array (0).
- **Reset mid-load:** reset during LOAD or DONE forces IDLE asynchronously, clears the array, and `done` is not pulsed.
- **Start latency:** `start` sampled at edge N → `in_ready`=1 and `busy`=1 from cycle N+1.
- **Throughput:** one byte per cycle when `in_valid` is held high. A minimal load is 1 start cycle + 32 LOAD cycles + 1 DONE cycle.
- **Completion:** the 32nd transfer at edge M → `done`=1 and `in_ready`=0 during cycle M+1 → `busy`=0 from cycle M+2.
- **Write visibility:** array writes take effect at the transfer edge; `rd_pixel` shows the new bit in the following cycle.
- **Back-pressure:** `in_valid` may drop at any time in LOAD; the loader waits indefinitely, with no timeout.

## Test plan
- **Reset clear:** assert `reset` mid-cycle, sweep all 1024 read addresses → `rd_pixel`=0 everywhere; `in_ready`/`busy`/`done`=0 immediately.
- **Full load:**
  - Stimulus: `start` with `sprite_sel`=2, stream bytes 0x01,0x80 repeated 16 times, `in_valid` held high.
  - Required: `done` pulses exactly 33 cycles after the `start` edge.
  - Required: sprite 2 reads 1 at cols 0 and 15 of every row, 0 elsewhere; sprites 0, 1 and 3 stay all-zero.
- **Back-pressure:** same load with `in_valid` toggled 1,0,1,0 → identical final contents; `done` at cycle 65 after start.
- **Abort:** `abort`=1 after 5 bytes of 0xFF into sprite 1, with `in_valid`=1 on the abort cycle.
  - Required: rows 0..1 are all 1; row 2 cols 0..7 are 1 and cols 8..15 are 0; no `done`; `busy`=0 next cycle.
- **Ignored start:** `start` with `sprite_sel`=3 pulsed during LOAD of sprite 0 → data lands only in sprite 0; sprite 3 stays 0.
- **Read-during-write:** hold `rd_sprite`=0, `rd_row`=0, `rd_col`=0 while writing byte 0x01 as the first byte → `rd_pixel`=0 before the transfer edge and 1 after it.
